gpio_intr_gen: RTL and testbench
================================

Name: gpio_intr_gen

Overview:
- Input-conditioning and edge-event stage directly upstream of the GPIO register block.
- Per pin: synchronises the asynchronous pad inputs, optionally debounces them, and drives the filtered pin level to the register block's gpio_in_data input.
- Per pin: detects rising/falling edges on the filtered level and emits one-cycle gpio_int_event pulses. These feed the interrupt status register, qualified by the posedge/negedge select and direction configuration.

Parameters:
- WD, 32, number of GPIO pins.
- DB_CNT_W, 4, width of each per-pin debounce counter and of cfg_db_count.
- PRE_W, 8, width of the shared debounce sample prescaler.

Ports:
- mclk  input  1  system clock.
- h_reset  input  1  reset; one clock; asynchronous, active-high.
- gpio_pad_in  input  WD  raw pad input levels, asynchronous to mclk.
- cfg_db_en  input  1  1 = debounce enabled, 0 = bypass (sync only).
- cfg_db_prescale  input  PRE_W  sample tick period minus 1, in mclk cycles.
- cfg_db_count  input  DB_CNT_W  consecutive mismatching ticks required, minus 1.
- cfg_gpio_dir_sel  input  WD  1 = pin is output; edge events are suppressed on that pin.
- cfg_gpio_posedge_int_sel  input  WD  enable rising-edge event per pin.
- cfg_gpio_negedge_int_sel  input  WD  enable falling-edge event per pin.
- gpio_in_data  output  WD  synchronised/filtered pin level.
- gpio_int_event  output  WD  registered one-cycle edge event pulses.

Behaviour:
- Reset (h_reset=1, async): sync flops, filt, filt_d, prescaler, all debounce counters, gpio_in_data and gpio_int_event are all 0.
- Synchroniser: two flops per pin, s1 <= gpio_pad_in and s2 <= s1. No reset-bypass path.
- Prescaler (shared by all pins):
  - tick = (presc >= cfg_db_prescale).
  - On tick, presc <= 0; otherwise presc <= presc+1.
  - cfg_db_prescale=0 gives a tick every cycle.
  - The >= comparison makes a lowered prescale take effect at once, with no wrap.
- Bypass (cfg_db_en=0): filt <= s2 every cycle; all counters held at 0.
- Debounce (cfg_db_en=1), per pin, evaluated only on tick cycles:
  - s2 == filt: cnt <= 0.
  - s2 != filt and cnt >= cfg_db_count: filt <= s2, cnt <= 0.
  - otherwise: cnt <= cnt+1. The counter saturates at all-ones and never wraps.
  - Non-tick cycles: filt and cnt hold.
  - Effect: a change is accepted after cfg_db_count+1 consecutive mismatching ticks. Any matching tick restarts the count, so glitches shorter than that window are rejected.
- Switching cfg_db_en 1->0 mid-count: filt follows s2 on the next cycle and counters clear. Switching 0->1: counting starts from 0.
- gpio_in_data = filt (a direct flop output).
- Edge detection:
  - filt_d <= filt.
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
  - gpio_int_event <= ((rise & posedge_sel) | (fall & negedge_sel)) & ~dir_sel.
  - Every pulse lasts exactly one cycle; back-to-back edges give separate pulses.
- Both select bits set: an event on either edge. Neither set: no event.
- Select and dir inputs are sampled in the cycle the edge is evaluated. An edge that occurs while the pin is an output, or while the select bit is 0, is lost and is not remembered.
- Latency, bypass mode: pad change settles before edge E1 -> s2 at E2, gpio_in_data at E3, gpio_int_event high after E4 for one cycle.
- Latency, debounce mode: event at E4 + the debounce acceptance delay, in ticks.
- After reset release, a pad held high is accepted as a 0->1 transition and produces a rising event if enabled. Firmware clears it; this is the required behaviour.
- Reset mid-debounce: the count is discarded and filtering restarts from 0 after release.

Test Plan:
- Bypass, posedge_sel[3]=1, dir_sel=0; pad[3] 0->1 before E1 -> gpio_in_data[3]=1 after E3; gpio_int_event = 32'h8 for exactly the cycle after E4; no further pulse.
- Debounce on, prescale=0, count=3; pad[0] high for 3 cycles then low -> no change on gpio_in_data[0], no event. High for 4+ cycles -> gpio_in_data[0]=1 after 4 ticks + 2 sync cycles, one event if posedge_sel[0]=1.
- prescale=4, count=1; pad[7] step -> acceptance at the 2nd tick (~10 cycles) after sync; the prescaler period is measured as 5 cycles.
- pos_sel=neg_sel=1 on pin 15; pad toggles 1->0->1 with 20 cycles per level in bypass -> three event pulses at 20-cycle spacing. Set dir_sel[15]=1 and repeat -> gpio_in_data still follows, zero events.
- All 32 pins toggle simultaneously with posedge_sel=32'hFFFF_FFFF -> gpio_int_event = 32'hFFFF_FFFF for one cycle. Falling edges with negedge_sel=0 -> no event.
- Assert h_reset mid-count (count=7, cnt at 5) -> outputs 0 immediately. After release, the pad held high requires 8 fresh ticks before gpio_in_data=1.

Source files
------------

// File: rtl/gpio_intr_gen_if.sv
// gpio_intr_gen_if: pad inputs, conditioning config and filtered level / edge-event outputs
interface gpio_intr_gen_if #(
    parameter int WD = 32,
    parameter int DB_CNT_W = 4,
    parameter int PRE_W = 8
);
    logic [WD-1:0] gpio_pad_in;
    logic cfg_db_en;
    logic [PRE_W-1:0] cfg_db_prescale;
    logic [DB_CNT_W-1:0] cfg_db_count;
    logic [WD-1:0] cfg_gpio_dir_sel;
    logic [WD-1:0] cfg_gpio_posedge_int_sel;
    logic [WD-1:0] cfg_gpio_negedge_int_sel;
    logic [WD-1:0] gpio_in_data;
    logic [WD-1:0] gpio_int_event;
    modport master (
        output gpio_pad_in, cfg_db_en, cfg_db_prescale, cfg_db_count,
        output cfg_gpio_dir_sel, cfg_gpio_posedge_int_sel, cfg_gpio_negedge_int_sel,
        input gpio_in_data, gpio_int_event
    );
    modport slave (
        input gpio_pad_in, cfg_db_en, cfg_db_prescale, cfg_db_count,
        input cfg_gpio_dir_sel, cfg_gpio_posedge_int_sel, cfg_gpio_negedge_int_sel,
        output gpio_in_data, gpio_int_event
    );
endinterface

// File: rtl/gpio_intr_gen.sv
// gpio_intr_gen: per-pin pad synchroniser, optional debounce filter and edge-event generator
module gpio_intr_gen #(
    parameter int WD = 32,
    parameter int DB_CNT_W = 4,
    parameter int PRE_W = 8
) (
    input logic mclk,
    input logic h_reset,
    gpio_intr_gen_if.slave bus
);
    logic [WD-1:0] s1, s2, filt, filt_d, filt_nx, evt_nx;
    logic [DB_CNT_W-1:0] cnt [WD];
    logic [DB_CNT_W-1:0] cnt_nx [WD];
    logic [PRE_W-1:0] presc;
    logic tick;
    // >= lets a lowered prescale take effect immediately instead of waiting for a wrap
    assign tick = presc >= bus.cfg_db_prescale;
    assign evt_nx = ((filt & ~filt_d & bus.cfg_gpio_posedge_int_sel) |
                     (~filt & filt_d & bus.cfg_gpio_negedge_int_sel)) & ~bus.cfg_gpio_dir_sel;
    assign bus.gpio_in_data = filt;
    always_comb begin
        filt_nx = filt;
        for (int i = 0; i < WD; i++) begin
            cnt_nx[i] = cnt[i];
            if (!bus.cfg_db_en) begin
                filt_nx[i] = s2[i];
                cnt_nx[i] = '0;
            end else if (tick) begin
                if (s2[i] == filt[i]) cnt_nx[i] = '0;
                else if (cnt[i] >= bus.cfg_db_count) begin
                    filt_nx[i] = s2[i];
                    cnt_nx[i] = '0;
                end else cnt_nx[i] = &cnt[i] ? cnt[i] : cnt[i] + 1'b1;
            end
        end
    end
    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            s1 <= '0;
            s2 <= '0;
            filt <= '0;
            filt_d <= '0;
            presc <= '0;
            for (int i = 0; i < WD; i++) cnt[i] <= '0;
            bus.gpio_int_event <= '0;
        end else begin
            s1 <= bus.gpio_pad_in;
            s2 <= s1;
            filt <= filt_nx;
            filt_d <= filt;
            presc <= tick ? '0 : presc + 1'b1;
            for (int i = 0; i < WD; i++) cnt[i] <= cnt_nx[i];
            bus.gpio_int_event <= evt_nx;
        end
    end
endmodule

// File: tb/tb_gpio_intr_gen.sv
// tb_gpio_intr_gen: vector table, directed corner sequences and randomized run against a window-based reference model
module tb_gpio_intr_gen;
    logic clk = 0;
    logic rst = 0;
    int n_chk = 0;
    int n_fail = 0;
    gpio_intr_gen_if bus ();
    gpio_intr_gen dut (.mclk(clk), .h_reset(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pad;
        logic [31:0] data;
        logic [31:0] evt;
    } vec_t;
    vec_t vt [11];

    // reference model: a pin accepts a new level once the last count+1 tick samples since its last restart all disagree with it
    logic [31:0] pad_hist [$];
    logic [31:0] samp_hist [$];
    logic [31:0] m_filt, m_filt_d, m_evt;
    int k;
    int last_acc [32];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic model_reset();
        pad_hist.delete();
        samp_hist.delete();
        m_filt = '0;
        m_filt_d = '0;
        m_evt = '0;
        k = 0;
        foreach (last_acc[i]) last_acc[i] = 0;
    endtask

    task automatic model_step();
        logic [31:0] s2, nf;
        int n, nw, p;
        bit ok;
        s2 = pad_hist.size() >= 2 ? pad_hist[pad_hist.size() - 2] : '0;
        nf = m_filt;
        p = int'(bus.cfg_db_prescale);
        if (!bus.cfg_db_en) begin
            nf = s2;
            foreach (last_acc[i]) last_acc[i] = samp_hist.size();
        end else if (k % (p + 1) == p) begin
            samp_hist.push_back(s2);
            n = samp_hist.size();
            nw = int'(bus.cfg_db_count) + 1;
            for (int i = 0; i < 32; i++) begin
                if (n - last_acc[i] >= nw) begin
                    ok = 1;
                    for (int j = 1; j <= nw; j++) if (samp_hist[n - j][i] == m_filt[i]) ok = 0;
                    if (ok) begin
                        nf[i] = s2[i];
                        last_acc[i] = n;
                    end
                end
            end
        end
        m_evt = ((m_filt & ~m_filt_d & bus.cfg_gpio_posedge_int_sel) |
                 (~m_filt & m_filt_d & bus.cfg_gpio_negedge_int_sel)) & ~bus.cfg_gpio_dir_sel;
        m_filt_d = m_filt;
        m_filt = nf;
        pad_hist.push_back(bus.gpio_pad_in);
        k++;
    endtask

    initial begin
        int first, rise, fall, cnt_ev, cnt_all, cnt_any;
        int ev_at [3];
        logic [31:0] acc_d, acc_e, act;
        bus.gpio_pad_in = '0;
        bus.cfg_db_en = 0;
        bus.cfg_db_prescale = '0;
        bus.cfg_db_count = '0;
        bus.cfg_gpio_dir_sel = '0;
        bus.cfg_gpio_posedge_int_sel = '0;
        bus.cfg_gpio_negedge_int_sel = '0;
        #2 rst = 1;
        #1;
        check("reset_data", bus.gpio_in_data, '0);
        check("reset_evt", bus.gpio_int_event, '0);
        step();
        rst = 0;

        // bypass latency on pin 3, rising only
        vt[0] = '{32'h8, 32'h0, 32'h0};
        vt[1] = '{32'h8, 32'h0, 32'h0};
        vt[2] = '{32'h8, 32'h8, 32'h0};
        vt[3] = '{32'h8, 32'h8, 32'h8};
        vt[4] = '{32'h8, 32'h8, 32'h0};
        vt[5] = '{32'h8, 32'h8, 32'h0};
        vt[6] = '{32'h0, 32'h8, 32'h0};
        vt[7] = '{32'h0, 32'h8, 32'h0};
        vt[8] = '{32'h0, 32'h0, 32'h0};
        vt[9] = '{32'h0, 32'h0, 32'h0};
        vt[10] = '{32'h0, 32'h0, 32'h0};
        bus.cfg_gpio_posedge_int_sel = 32'h8;
        for (int i = 0; i < 11; i++) begin
            bus.gpio_pad_in = vt[i].pad;
            step();
            check($sformatf("vec%0d_data", i), bus.gpio_in_data, vt[i].data);
            check($sformatf("vec%0d_evt", i), bus.gpio_int_event, vt[i].evt);
        end

        // debounce glitch rejection and acceptance, prescale 0, count 3
        bus.cfg_db_en = 1;
        bus.cfg_db_count = 4'd3;
        bus.cfg_gpio_posedge_int_sel = 32'h1;
        pulse_rst();
        acc_d = '0;
        acc_e = '0;
        for (int i = 0; i < 15; i++) begin
            bus.gpio_pad_in = i < 3 ? 32'h1 : 32'h0;
            step();
            acc_d |= bus.gpio_in_data;
            acc_e |= bus.gpio_int_event;
        end
        check("glitch_data", acc_d, '0);
        check("glitch_evt", acc_e, '0);
        bus.gpio_pad_in = 32'h1;
        first = 0;
        cnt_ev = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (bus.gpio_in_data[0] && first == 0) first = i;
            cnt_ev += int'(bus.gpio_int_event[0]);
        end
        check("db_latency", first, 6);
        check("db_events", cnt_ev, 1);

        // prescale 4, count 1 on pin 7: two ticks per acceptance
        bus.gpio_pad_in = '0;
        bus.cfg_db_prescale = 8'd4;
        bus.cfg_db_count = 4'd1;
        bus.cfg_gpio_posedge_int_sel = '0;
        pulse_rst();
        bus.gpio_pad_in = 32'h80;
        rise = 0;
        fall = 0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 11) bus.gpio_pad_in = '0;
            step();
            if (bus.gpio_in_data[7] && rise == 0) rise = i;
            if (!bus.gpio_in_data[7] && rise != 0 && fall == 0) fall = i;
        end
        check("presc_rise", rise, 10);
        check("presc_fall", fall, 20);
        check("presc_period", (fall - rise) / 2, 5);

        // pin 15 both edges in bypass, then as output
        bus.cfg_db_en = 0;
        bus.cfg_gpio_posedge_int_sel = 32'h8000;
        bus.cfg_gpio_negedge_int_sel = 32'h8000;
        for (int i = 0; i < 5; i++) step();
        cnt_ev = 0;
        for (int i = 0; i < 70; i++) begin
            bus.gpio_pad_in = (i < 20 || i >= 40) ? 32'h8000 : 32'h0;
            step();
            if (bus.gpio_int_event != 0) begin
                if (cnt_ev < 3) ev_at[cnt_ev] = i;
                cnt_ev++;
            end
        end
        check("both_edges_count", cnt_ev, 3);
        check("both_edges_gap1", ev_at[1] - ev_at[0], 20);
        check("both_edges_gap2", ev_at[2] - ev_at[1], 20);
        bus.cfg_gpio_dir_sel = 32'h8000;
        cnt_ev = 0;
        for (int i = 0; i < 70; i++) begin
            bus.gpio_pad_in = (i >= 20 && i < 40) ? 32'h8000 : 32'h0;
            step();
            if (bus.gpio_int_event != 0) cnt_ev++;
            if (i == 30) check("dir_follow_hi", bus.gpio_in_data, 32'h8000);
        end
        check("dir_events", cnt_ev, 0);
        check("dir_follow_lo", bus.gpio_in_data, 32'h0);

        // all pins together, rising only
        bus.cfg_gpio_dir_sel = '0;
        bus.cfg_gpio_posedge_int_sel = '1;
        bus.cfg_gpio_negedge_int_sel = '0;
        bus.gpio_pad_in = '1;
        cnt_all = 0;
        cnt_any = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt_all += int'(bus.gpio_int_event == '1);
            cnt_any += int'(bus.gpio_int_event != '0);
        end
        check("all_rise_full", cnt_all, 1);
        check("all_rise_once", cnt_any, 1);
        bus.gpio_pad_in = '0;
        acc_e = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            acc_e |= bus.gpio_int_event;
        end
        check("all_fall_evt", acc_e, '0);
        check("all_fall_data", bus.gpio_in_data, '0);

        // reset in the middle of a count of 8
        bus.cfg_db_en = 1;
        bus.cfg_db_prescale = '0;
        bus.cfg_db_count = 4'd7;
        bus.cfg_gpio_posedge_int_sel = '0;
        bus.gpio_pad_in = 32'h2;
        pulse_rst();
        for (int i = 0; i < 20; i++) step();
        check("pre_rst_data", bus.gpio_in_data, 32'h2);
        bus.gpio_pad_in = 32'h3;
        for (int i = 0; i < 7; i++) step();
        rst = 1;
        #1;
        check("rst_async_data", bus.gpio_in_data, '0);
        check("rst_async_evt", bus.gpio_int_event, '0);
        step();
        rst = 0;
        first = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (bus.gpio_in_data == 32'h3 && first == 0) first = i;
        end
        check("rst_restart", first, 10);

        // randomized run against the reference model
        for (int seg = 0; seg < 10; seg++) begin
            bus.cfg_db_en = 1'($urandom_range(0, 1));
            bus.cfg_db_prescale = 8'($urandom_range(0, 3));
            bus.cfg_db_count = 4'($urandom_range(0, 3));
            bus.cfg_gpio_dir_sel = $urandom & $urandom;
            bus.cfg_gpio_posedge_int_sel = $urandom;
            bus.cfg_gpio_negedge_int_sel = $urandom;
            act = $urandom;
            pulse_rst();
            model_reset();
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 15) == 0) bus.cfg_gpio_dir_sel = $urandom & $urandom;
                if ($urandom_range(0, 15) == 0) bus.cfg_gpio_posedge_int_sel = $urandom;
                if ($urandom_range(0, 15) == 0) bus.cfg_gpio_negedge_int_sel = $urandom;
                if ($urandom_range(0, 63) == 0) bus.cfg_db_en = ~bus.cfg_db_en;
                bus.gpio_pad_in ^= $urandom & $urandom & $urandom & act & ((seg % 2 == 1) ? $urandom : 32'hFFFF_FFFF);
                model_step();
                step();
                check("rand_data", bus.gpio_in_data, m_filt);
                check("rand_evt", bus.gpio_int_event, m_evt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
